pixel_write_arbiter: RTL and testbench

Turns 32-bit pixel command words written by the HPS through the `set_pixel` PIO export into framebuffer writes. It shares a single-port framebuffer RAM between those writes and the display scan-out reader.
- Commands are buffered in a small FIFO and decoded by a sequencer that handles single-pixel writes and full-screen clears.
- Scan-out always has priority for the RAM port.
- Status goes back to software via a PIO-readable word.

---
 rtl/pixel_write_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_arbiter.sv
// Pixel command sequencer: buffers HPS pixel/clear commands and shares a
// single-port framebuffer with the scan-out reader, which always wins the port.
module pixel_write_arbiter #(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 240,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [31:0]        set_pixel_cmd,
    input  logic               clear_flags,
    output logic [31:0]        status,
    input  logic               scan_req,
    input  logic [ADDR_W-1:0]  scan_addr,
    output logic               scan_grant,
    output logic               scan_valid,
    output logic [COLOR_W-1:0] scan_rdata,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic               fb_we,
    output logic [COLOR_W-1:0] fb_wdata,
    input  logic [COLOR_W-1:0] fb_rdata
);

    localparam int unsigned NPIX  = H_RES * V_RES;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {S_IDLE, S_PIXEL, S_CLEAR} state_t;

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_cmd_q;
    logic               r_last_tog, r_q_vld, r_armed;
    logic               r_ack, r_ovf, r_oob;
    logic [31:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [COLOR_W-1:0] r_color, w_color_nxt;
    logic               r_rd_pend, r_scan_valid;
    logic [COLOR_W-1:0] r_scan_rdata;

    logic               w_detect, w_full, w_empty, w_push, w_pop, w_oob_set, w_wr, w_busy;
    logic [31:0]        w_head;
    logic [1:0]         w_op;
    logic [8:0]         w_x;
    logic [7:0]         w_y;
    logic               w_in_bounds;
    logic [ADDR_W-1:0]  w_pix_addr;
    logic [12:0]        w_unused_bits;

    // Toggle detection is held off until cmd_q holds a real sample, so a
    // toggle level that survives reset never looks like a new command.
    assign w_detect = r_armed && (r_cmd_q[31] != r_last_tog);
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = w_detect && !w_full;

    assign w_head      = r_fifo[r_rd_ptr];
    assign w_op        = w_head[30:29];
    assign w_x         = w_head[28:20];
    assign w_y         = w_head[19:12];
    assign w_in_bounds = (32'(w_x) < H_RES) && (32'(w_y) < V_RES);
    assign w_pix_addr  = ADDR_W'(w_y) * ADDR_W'(H_RES) + ADDR_W'(w_x);
    assign w_unused_bits = {w_head[31], w_head[11:0] >> COLOR_W};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cmd_q    <= '0;
            r_last_tog <= 1'b0;
            r_q_vld    <= 1'b0;
            r_armed    <= 1'b0;
            r_ack      <= 1'b0;
            r_ovf      <= 1'b0;
            r_oob      <= 1'b0;
        end else begin
            r_cmd_q    <= set_pixel_cmd;
            r_last_tog <= r_cmd_q[31];
            r_q_vld    <= 1'b1;
            r_armed    <= r_q_vld;
            r_ack      <= r_ack ^ w_detect;
            r_ovf      <= (w_detect && w_full) || (r_ovf && !clear_flags);
            r_oob      <= w_oob_set || (r_oob && !clear_flags);
        end
    end

    // Command FIFO; a pop never frees a slot for a push in the same cycle.
    always_ff @(posedge clk_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_cmd_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_color <= w_color_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_color_nxt = r_color;
        w_pop       = 1'b0;
        w_oob_set   = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_op == 2'b00) begin
                        if (w_in_bounds) begin
                            w_addr_nxt  = w_pix_addr;
                            w_color_nxt = w_head[COLOR_W-1:0];
                            w_state_nxt = S_PIXEL;
                        end else begin
                            w_oob_set = 1'b1;
                        end
                    end else if (w_op == 2'b01) begin
                        w_addr_nxt  = '0;
                        w_color_nxt = w_head[COLOR_W-1:0];
                        w_state_nxt = S_CLEAR;
                    end
                end
            end
            S_PIXEL: begin
                if (!scan_req) begin
                    w_wr        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (!scan_req) begin
                    w_wr = 1'b1;
                    if (r_addr == LAST_ADDR) w_state_nxt = S_IDLE;
                    else                     w_addr_nxt  = r_addr + ADDR_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Scan read data arrives one cycle after the RAM samples the address.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rd_pend    <= 1'b0;
            r_scan_valid <= 1'b0;
            r_scan_rdata <= '0;
        end else begin
            r_rd_pend    <= scan_req;
            r_scan_valid <= r_rd_pend;
            if (r_rd_pend) r_scan_rdata <= fb_rdata;
        end
    end

    assign w_busy     = (r_state != S_IDLE) || !w_empty;
    assign status     = {25'd0, 3'(r_count), r_ack, r_oob, r_ovf, w_busy};
    assign scan_grant = scan_req;
    assign scan_valid = r_scan_valid;
    assign scan_rdata = r_scan_rdata;
    assign fb_we      = w_wr;
    assign fb_addr    = scan_req ? scan_addr : r_addr;
    assign fb_wdata   = r_color;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter on a small 20x10 framebuffer with a
// behavioural 1-cycle-latency RAM and a log of every committed write.
module tb_pixel_write_arbiter;

    localparam int unsigned H  = 20;
    localparam int unsigned V  = 10;
    localparam int unsigned NP = H * V;
    localparam int unsigned CW = 8;
    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   set_pixel_cmd;
    logic          clear_flags;
    logic [31:0]   status;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_grant;
    logic          scan_valid;
    logic [CW-1:0] scan_rdata;
    logic [AW-1:0] fb_addr;
    logic          fb_we;
    logic [CW-1:0] fb_wdata;
    logic [CW-1:0] fb_rdata;

    always #5 clk = ~clk;

    pixel_write_arbiter #(
        .H_RES(H), .V_RES(V), .COLOR_W(CW), .ADDR_W(AW), .FIFO_DEPTH(4)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .set_pixel_cmd(set_pixel_cmd),
        .clear_flags(clear_flags), .status(status), .scan_req(scan_req),
        .scan_addr(scan_addr), .scan_grant(scan_grant), .scan_valid(scan_valid),
        .scan_rdata(scan_rdata), .fb_addr(fb_addr), .fb_we(fb_we),
        .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
    );

    logic [7:0]    mem [256];
    logic [AW-1:0] wq_a [$];
    logic [CW-1:0] wq_d [$];
    int            viol = 0;

    // RAM model plus write log; memory is preset to 0xEE while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
        end else if (fb_we) begin
            mem[fb_addr[7:0]] <= fb_wdata;
            wq_a.push_back(fb_addr);
            wq_d.push_back(fb_wdata);
            if (scan_req) viol++;
        end
        fb_rdata <= mem[fb_addr[7:0]];
    end

    int   checks = 0;
    int   failures = 0;
    logic tog = 1'b0;
    logic exp_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [8:0] x, input logic [7:0] y,
                        input logic [11:0] col);
        tog = ~tog;
        exp_ack = ~exp_ack;
        set_pixel_cmd = {tog, op, x, y, col};
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (status[0] && n < bound) begin
            step();
            n++;
        end
        chk(name, 32'(status[0]), 32'd0);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [8:0]    x;
        logic [7:0]    y;
        logic [11:0]   col;
        bit            wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        bit            oob;
    } vec_t;

    vec_t vt [9];

    initial begin
        int base, k, verr, derr, aerr, merr;
        bit hreq [$];
        logic [7:0] hdat [$];

        vt[0] = '{2'b00, 9'd5,   8'd2,   12'h03C, 1'b1, 17'd45,  8'h3C, 1'b0};
        vt[1] = '{2'b00, 9'd19,  8'd9,   12'h0FF, 1'b1, 17'd199, 8'hFF, 1'b0};
        vt[2] = '{2'b00, 9'd0,   8'd0,   12'h001, 1'b1, 17'd0,   8'h01, 1'b0};
        vt[3] = '{2'b00, 9'd3,   8'd1,   12'hA5C, 1'b1, 17'd23,  8'h5C, 1'b0};
        vt[4] = '{2'b00, 9'd20,  8'd0,   12'h011, 1'b0, 17'd0,   8'h00, 1'b1};
        vt[5] = '{2'b00, 9'd0,   8'd10,  12'h022, 1'b0, 17'd0,   8'h00, 1'b1};
        vt[6] = '{2'b00, 9'd511, 8'd255, 12'h033, 1'b0, 17'd0,   8'h00, 1'b1};
        vt[7] = '{2'b11, 9'd1,   8'd1,   12'h077, 1'b0, 17'd0,   8'h00, 1'b0};
        vt[8] = '{2'b10, 9'd2,   8'd2,   12'h066, 1'b0, 17'd0,   8'h00, 1'b0};

        rst_n = 1'b0;
        set_pixel_cmd = '0;
        clear_flags = 1'b0;
        scan_req = 1'b0;
        scan_addr = '0;
        repeat (3) step();
        chk("reset_status", status, 32'd0);
        chk("reset_fb_we", 32'(fb_we), 32'd0);
        chk("reset_scan_valid", 32'(scan_valid), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // Single pixel with exact edge timing.
        base = wq_a.size();
        send(2'b00, 9'd5, 8'd2, 12'h03C);
        step();
        chk("sp_e0_we", 32'(fb_we), 32'd0);
        step();
        chk("sp_e1_busy", 32'(status[0]), 32'd1);
        chk("sp_e1_level", 32'(status[6:4]), 32'd1);
        chk("sp_e1_ack", 32'(status[3]), 32'(exp_ack));
        step();
        chk("sp_e2_we", 32'(fb_we), 32'd1);
        chk("sp_e2_addr", 32'(fb_addr), 32'd45);
        chk("sp_e2_data", 32'(fb_wdata), 32'h3C);
        step();
        chk("sp_e3_we", 32'(fb_we), 32'd0);
        chk("sp_e3_busy", 32'(status[0]), 32'd0);
        chk("sp_e3_mem", 32'(mem[45]), 32'h3C);
        chk("sp_e3_count", 32'(wq_a.size() - base), 32'd1);

        for (int i = 0; i < 9; i++) begin
            base = wq_a.size();
            send(vt[i].op, vt[i].x, vt[i].y, vt[i].col);
            repeat (6) step();
            chk($sformatf("v%0d_wr_count", i), 32'(wq_a.size() - base), vt[i].wr ? 32'd1 : 32'd0);
            if (vt[i].wr && wq_a.size() > base) begin
                chk($sformatf("v%0d_addr", i), 32'(wq_a[base]), 32'(vt[i].addr));
                chk($sformatf("v%0d_data", i), 32'(wq_d[base]), 32'(vt[i].data));
            end
            chk($sformatf("v%0d_oob", i), 32'(status[2]), 32'(vt[i].oob));
            chk($sformatf("v%0d_ovf", i), 32'(status[1]), 32'd0);
            chk($sformatf("v%0d_ack", i), 32'(status[3]), 32'(exp_ack));
            chk($sformatf("v%0d_idle", i), 32'(status[0]) | 32'(status[6:4]), 32'd0);
            pulse_clear();
            chk($sformatf("v%0d_oob_cleared", i), 32'(status[2]), 32'd0);
        end

        // Flag set and clear landing on the same edge: set wins.
        send(2'b00, 9'd25, 8'd0, 12'h0);
        step();
        step();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("set_clear_collide", 32'(status[2]), 32'd1);
        pulse_clear();
        chk("collide_cleared", 32'(status[2]), 32'd0);

        // Clear under contention: scan every 4th cycle.
        base = wq_a.size();
        verr = 0; derr = 0;
        send(2'b01, 9'd0, 8'd0, 12'h000);
        k = 0;
        while (k < 1000) begin
            if (k >= 2) begin
                if (scan_valid !== hreq[k-2]) verr++;
                if (hreq[k-2] && scan_rdata !== hdat[k-2]) derr++;
            end
            if (k >= 4 && !status[0]) break;
            scan_req = (k % 4 == 3);
            scan_addr = AW'(k % NP);
            hreq.push_back(k % 4 == 3);
            hdat.push_back(mem[k % NP]);
            step();
            k++;
        end
        scan_req = 1'b0;
        chk("clr_done", 32'(status[0]), 32'd0);
        chk("clr_count", 32'(wq_a.size() - base), 32'(NP));
        aerr = 0; merr = 0;
        for (int i = 0; i < int'(NP) && base + i < wq_a.size(); i++) begin
            if (wq_a[base+i] !== AW'(i) || wq_d[base+i] !== 8'h00) aerr++;
            if (mem[i] !== 8'h00) merr++;
        end
        chk("clr_order", 32'(aerr), 32'd0);
        chk("clr_mem", 32'(merr), 32'd0);
        chk("clr_no_write_on_scan", 32'(viol), 32'd0);
        chk("clr_scan_valid", 32'(verr), 32'd0);
        chk("clr_scan_rdata", 32'(derr), 32'd0);
        chk("clr_stalls_seen", 32'(k > int'(NP) + 40), 32'd1);

        // Overflow: five pixels queued behind a clear.
        base = wq_a.size();
        send(2'b01, 9'd0, 8'd0, 12'h011);
        step();
        for (int i = 1; i <= 5; i++) begin
            send(2'b00, 9'(i), 8'd0, 12'(32'h20 + i));
            step();
            step();
        end
        step();
        step();
        chk("ovf_level", 32'(status[6:4]), 32'd4);
        chk("ovf_flag", 32'(status[1]), 32'd1);
        chk("ovf_ack", 32'(status[3]), 32'(exp_ack));
        wait_idle(600, "ovf_drain_timeout");
        chk("ovf_count", 32'(wq_a.size() - base), 32'(NP + 4));
        for (int i = 0; i < 4; i++) begin
            if (base + int'(NP) + i < wq_a.size()) begin
                chk($sformatf("ovf_px%0d_addr", i), 32'(wq_a[base+NP+i]), 32'(i + 1));
                chk($sformatf("ovf_px%0d_data", i), 32'(wq_d[base+NP+i]), 32'(8'h21 + i));
            end
        end
        chk("ovf_dropped_mem", 32'(mem[5]), 32'h11);
        pulse_clear();
        chk("ovf_cleared", 32'(status[1]), 32'd0);

        // Reset in the middle of a clear with the toggle held high.
        if (tog == 1'b1) begin
            send(2'b11, 9'd0, 8'd0, 12'h0);
            repeat (4) step();
        end
        send(2'b01, 9'd0, 8'd0, 12'h0AA);
        repeat (20) step();
        chk("rst_pre_busy", 32'(status[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_status", status, 32'd0);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        chk("rst_scan", {30'd0, scan_valid, scan_grant}, 32'd0);
        chk("rst_scan_rdata", 32'(scan_rdata), 32'd0);
        exp_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        base = wq_a.size();
        repeat (10) step();
        chk("rst_no_cmd_writes", 32'(wq_a.size() - base), 32'd0);
        chk("rst_no_cmd_status", status, 32'd0);
        send(2'b00, 9'd7, 8'd3, 12'h05A);
        repeat (6) step();
        chk("rst_new_cmd_count", 32'(wq_a.size() - base), 32'd1);
        if (wq_a.size() > base) chk("rst_new_cmd_addr", 32'(wq_a[base]), 32'd67);
        chk("rst_new_cmd_ack", 32'(status[3]), 32'(exp_ack));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
